// File: rtl/dlsc_dvi_tx_pkg.sv
// Shared definitions for the DVI/parallel-RGB transmitter path: pad-word layout,
// sync-pin polarity helpers and the colour-bar table.
package dlsc_dvi_tx_pkg;

  // Control-bit positions above the data field of a pad word.
  localparam int unsigned DE_OFS    = 0;
  localparam int unsigned HSYNC_OFS = 1;
  localparam int unsigned VSYNC_OFS = 2;
  localparam int unsigned CTRL_BITS = 3;

  typedef struct packed {
    logic vsync;
    logic hsync;
    logic de;
  } ctrl_t;

  // Entry i is (7 - i); bit (c mod 3) of an entry lights channel c.
  localparam logic [2:0] BAR_COLORS [8] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

  function automatic int unsigned out_bits(input int unsigned channels,
                                           input int unsigned bits,
                                           input int unsigned ddr);
    return (ddr != 0) ? (channels * bits) / 2 : channels * bits;
  endfunction

  function automatic ctrl_t pin_ctrl(input logic vsync, input logic hsync, input logic de,
                                     input logic vsync_pol, input logic hsync_pol);
    ctrl_t c;
    c.vsync = vsync_pol ? vsync : ~vsync;
    c.hsync = hsync_pol ? hsync : ~hsync;
    c.de    = de;
    return c;
  endfunction

  // Control field of the idle word; the data field is always zero.
  function automatic ctrl_t idle_ctrl(input logic vsync_pol, input logic hsync_pol);
    return pin_ctrl(1'b0, 1'b0, 1'b0, vsync_pol, hsync_pol);
  endfunction

endpackage

// File: rtl/dlsc_dvi_tx_formatter_if.sv
// Pixel stream from the timing generator into the DVI transmit formatter.
interface dlsc_dvi_tx_formatter_if #(
    parameter int DATA_BITS = 24
) ();
    logic                 px_en;
    logic                 px_vsync;
    logic                 px_hsync;
    logic                 px_valid;
    logic [DATA_BITS-1:0] px_data;

    modport master (output px_en, px_vsync, px_hsync, px_valid, px_data);
    modport slave  (input  px_en, px_vsync, px_hsync, px_valid, px_data);
endinterface

// File: rtl/dlsc_dvi_tx_geom_mon.sv
// Frame geometry monitor: measures line length and frame height and flags lines
// whose length differs from the previous line. pix_cnt is exported only when
// DLSC_DVI_TX_PATTERN_EN is defined.
module dlsc_dvi_tx_geom_mon #(
    parameter int CNT_BITS = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic                vsync,
    input  logic                clear,
`ifdef DLSC_DVI_TX_PATTERN_EN
    output logic [CNT_BITS-1:0] pix_cnt,
`endif
    output logic [CNT_BITS-1:0] stat_pixels,
    output logic [CNT_BITS-1:0] stat_lines,
    output logic                stat_error
);
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    logic                valid_q;
    logic                vsync_q;
    logic [CNT_BITS-1:0] pix_cnt_q;
    logic [CNT_BITS-1:0] line_cnt;
    logic [CNT_BITS-1:0] line_cnt_inc;
    logic                line_end;
    logic                frame_start;
    logic                len_err;

    assign line_end     = valid_q & ~valid;
    assign frame_start  = vsync & ~vsync_q;
    assign line_cnt_inc = (line_cnt == CNT_MAX) ? line_cnt : line_cnt + CNT_BITS'(1);
    // The first line of a frame (or after reset) has no reference length.
    assign len_err      = line_end && (line_cnt != '0) && (pix_cnt_q != stat_pixels);

`ifdef DLSC_DVI_TX_PATTERN_EN
    assign pix_cnt = pix_cnt_q;
`endif

    // NOTE: every register here uses <= so all updates see the pre-edge values
    // of their neighbours, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            vsync_q     <= 1'b0;
            pix_cnt_q   <= '0;
            line_cnt    <= '0;
            stat_pixels <= '0;
            stat_lines  <= '0;
            stat_error  <= 1'b0;
        end else begin
            valid_q <= valid;
            vsync_q <= vsync;

            if (line_end) begin
                stat_pixels <= pix_cnt_q;
                pix_cnt_q   <= '0;
            end else if (valid && (pix_cnt_q != CNT_MAX)) begin
                pix_cnt_q <= pix_cnt_q + CNT_BITS'(1);
            end

            // A line ending on the vsync edge still belongs to the old frame.
            if (frame_start) begin
                stat_lines <= line_end ? line_cnt_inc : line_cnt;
                line_cnt   <= '0;
            end else if (line_end) begin
                line_cnt <= line_cnt_inc;
            end

            if (len_err) begin
                stat_error <= 1'b1;
            end else if (clear) begin
                stat_error <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/dlsc_dvi_tx_formatter.sv
// Pixel-to-pad formatter for DVI transmitters: DDR/SDR split, blanking, sync polarity
// and output pipeline. Colour bars are built in when DLSC_DVI_TX_PATTERN_EN is defined.
module dlsc_dvi_tx_formatter
    import dlsc_dvi_tx_pkg::*;
#(
    parameter int CHANNELS  = 3,
    parameter int BITS      = 8,
    parameter int DDR       = 1,
    parameter int PIPE      = 2,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int CNT_BITS  = 12,
    parameter int BAR_SHIFT = 5
) (
    input  logic                                        clk,
    input  logic                                        rst,
    dlsc_dvi_tx_formatter_if.slave                      px,
    input  logic                                        cfg_clear,
`ifdef DLSC_DVI_TX_PATTERN_EN
    input  logic                                        cfg_pattern,
`endif
    output logic [out_bits(CHANNELS, BITS, DDR)+2:0]    out_a,
    output logic [out_bits(CHANNELS, BITS, DDR)+2:0]    out_b,
    output logic [CNT_BITS-1:0]                         stat_pixels,
    output logic [CNT_BITS-1:0]                         stat_lines,
    output logic                                        stat_error
);
    localparam int PX_BITS  = CHANNELS * BITS;
    localparam int OUT_BITS = out_bits(CHANNELS, BITS, DDR);
    localparam int W        = OUT_BITS + CTRL_BITS;

    typedef logic [W-1:0] word_t;

    localparam word_t IDLE_WORD = {idle_ctrl(VSYNC_POL != 0, HSYNC_POL != 0), {OUT_BITS{1'b0}}};

    logic [PX_BITS-1:0]  src_data;
    logic [PX_BITS-1:0]  vis_data;
    logic [OUT_BITS-1:0] dat_a;
    logic [OUT_BITS-1:0] dat_b;
    ctrl_t               ctrl;
    word_t               word_a;
    word_t               word_b;
    word_t               pipe_a [PIPE];
    word_t               pipe_b [PIPE];

`ifdef DLSC_DVI_TX_PATTERN_EN
    logic [CNT_BITS-1:0] pix_cnt;
    logic [2:0]          bar_idx;

    assign bar_idx = 3'(pix_cnt >> BAR_SHIFT);
`endif

    dlsc_dvi_tx_geom_mon #(
        .CNT_BITS (CNT_BITS)
    ) u_geom_mon (
        .clk         (clk),
        .rst         (rst),
        .valid       (px.px_valid),
        .vsync       (px.px_vsync),
        .clear       (cfg_clear),
`ifdef DLSC_DVI_TX_PATTERN_EN
        .pix_cnt     (pix_cnt),
`endif
        .stat_pixels (stat_pixels),
        .stat_lines  (stat_lines),
        .stat_error  (stat_error)
    );

    // NOTE: src_data gets its default before any conditional override, so no
    // path through this block leaves it unassigned and no latch is inferred.
    always_comb begin
        src_data = px.px_data;
`ifdef DLSC_DVI_TX_PATTERN_EN
        if (cfg_pattern) begin
            for (int c = 0; c < CHANNELS; c++) begin
                src_data[c*BITS +: BITS] = {BITS{BAR_COLORS[bar_idx][c % 3]}};
            end
        end
`endif
        vis_data = px.px_valid ? src_data : '0;
    end

    generate
        if (DDR != 0) begin : g_ddr
            assign dat_a = vis_data[OUT_BITS-1:0];
            assign dat_b = vis_data[2*OUT_BITS-1:OUT_BITS];
        end else begin : g_sdr
            assign dat_a = vis_data;
            assign dat_b = vis_data;
        end
    endgenerate

    assign ctrl   = pin_ctrl(px.px_vsync, px.px_hsync, px.px_valid, VSYNC_POL != 0, HSYNC_POL != 0);
    assign word_a = px.px_en ? {ctrl, dat_a} : IDLE_WORD;
    assign word_b = px.px_en ? {ctrl, dat_b} : IDLE_WORD;

    // NOTE: the pipeline is reset despite being a register array, because the
    // pads must show a legal idle level from the first cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE; i++) begin
                pipe_a[i] <= IDLE_WORD;
                pipe_b[i] <= IDLE_WORD;
            end
        end else begin
            pipe_a[0] <= word_a;
            pipe_b[0] <= word_b;
            for (int i = 1; i < PIPE; i++) begin
                pipe_a[i] <= pipe_a[i-1];
                pipe_b[i] <= pipe_b[i-1];
            end
        end
    end

    assign out_a = pipe_a[PIPE-1];
    assign out_b = pipe_b[PIPE-1];
endmodule

// File: tb/tb_dlsc_dvi_tx_formatter.sv
// Bench for dlsc_dvi_tx_formatter: scoreboard on the pad words plus directed
// checks of the geometry monitor; pattern steps run when DLSC_DVI_TX_PATTERN_EN is set.
module tb_dlsc_dvi_tx_formatter;
  localparam int CHANNELS  = 3;
  localparam int BITS      = 8;
  localparam int DDR       = 1;
  localparam int PIPE      = 2;
  localparam int HSYNC_POL = 0;
  localparam int VSYNC_POL = 0;
  localparam int CNT_BITS  = 12;
  localparam int BAR_SHIFT = 5;
  localparam int DW        = CHANNELS * BITS;
  localparam int OB        = DW / 2;
  localparam int W         = OB + 3;

  localparam logic [W-1:0] IDLE = {VSYNC_POL == 0, HSYNC_POL == 0, 1'b0, {OB{1'b0}}};
  localparam logic [DW-1:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'hFF00FF, 24'hFF0000,
                                         24'h00FFFF, 24'h00FF00, 24'h0000FF, 24'h000000};

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  logic                clk;
  logic                rst;
  logic                cfg_clear;
  logic                cfg_pattern;
  logic [W-1:0]        out_a;
  logic [W-1:0]        out_b;
  logic [CNT_BITS-1:0] stat_pixels;
  logic [CNT_BITS-1:0] stat_lines;
  logic                stat_error;

  int   n_cmp;
  int   n_fail;
  int   model_cnt;
  logic model_prev_valid;
  exp_t sb [$];

  dlsc_dvi_tx_formatter_if #(.DATA_BITS(DW)) px ();

  dlsc_dvi_tx_formatter #(
    .CHANNELS (CHANNELS), .BITS (BITS), .DDR (DDR), .PIPE (PIPE),
    .HSYNC_POL (HSYNC_POL), .VSYNC_POL (VSYNC_POL),
    .CNT_BITS (CNT_BITS), .BAR_SHIFT (BAR_SHIFT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .px          (px),
    .cfg_clear   (cfg_clear),
`ifdef DLSC_DVI_TX_PATTERN_EN
    .cfg_pattern (cfg_pattern),
`endif
    .out_a       (out_a),
    .out_b       (out_b),
    .stat_pixels (stat_pixels),
    .stat_lines  (stat_lines),
    .stat_error  (stat_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One pixel clock: compare the word due now, then drive the next input and
  // queue the word it must produce PIPE cycles later.
  task automatic step(input logic en, input logic vs, input logic hs, input logic valid,
                      input logic [DW-1:0] data, input logic clr, input logic pat);
    exp_t        e;
    exp_t        got;
    logic [DW-1:0] d;
    logic        vpin;
    logic        hpin;
    @(negedge clk);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check("sb_out_a", 32'(out_a), 32'(got.a));
      check("sb_out_b", 32'(out_b), 32'(got.b));
    end
    rst            = 1'b0;
    px.px_en       = en;
    px.px_vsync    = vs;
    px.px_hsync    = hs;
    px.px_valid    = valid;
    px.px_data     = data;
    cfg_clear      = clr;
    cfg_pattern    = pat;
    d = valid ? data : '0;
`ifdef DLSC_DVI_TX_PATTERN_EN
    if (pat && valid) d = BARS[(model_cnt >> BAR_SHIFT) % 8];
`endif
    vpin = (VSYNC_POL != 0) ? vs : ~vs;
    hpin = (HSYNC_POL != 0) ? hs : ~hs;
    if (!en) begin
      e.a = IDLE;
      e.b = IDLE;
    end else begin
      e.a = {vpin, hpin, valid, d[OB-1:0]};
      e.b = {vpin, hpin, valid, d[DW-1:OB]};
    end
    sb.push_back(e);
    if (valid) begin
      if (model_cnt < (1 << CNT_BITS) - 1) model_cnt++;
    end else if (model_prev_valid) begin
      model_cnt = 0;
    end
    model_prev_valid = valid;
  endtask

  task automatic blank(input logic clr);
    step(1'b1, 1'b0, 1'b0, 1'b0, DW'($urandom), clr, 1'b0);
  endtask

  task automatic vsync_pulse();
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, DW'($urandom), 1'b0, 1'b0);
    repeat (2) blank(1'b0);
  endtask

  // npix active pixels followed by nblank blanking cycles with an hsync pulse.
  task automatic line(input int npix, input int nblank, input logic pat, input int en_off_at,
                      input logic clr_end, input logic vs_end);
    for (int i = 0; i < npix; i++) begin
      step(!(en_off_at >= 0 && i >= en_off_at && i < en_off_at + 5),
           1'b0, 1'b0, 1'b1, DW'($urandom), 1'b0, pat);
    end
    for (int j = 0; j < nblank; j++) begin
      step(1'b1, vs_end && (j < 3), (j >= 2) && (j < 6), 1'b0, DW'($urandom),
           clr_end && (j == 0), pat);
    end
  endtask

  initial begin
    n_cmp            = 0;
    n_fail           = 0;
    model_cnt        = 0;
    model_prev_valid = 1'b0;
    rst              = 1'b1;
    cfg_clear        = 1'b0;
    cfg_pattern      = 1'b0;
    px.px_en         = 1'b0;
    px.px_vsync      = 1'b0;
    px.px_hsync      = 1'b0;
    px.px_valid      = 1'b0;
    px.px_data       = '0;

    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst         = 1'b1;
      px.px_en    = 1'($urandom);
      px.px_vsync = 1'($urandom);
      px.px_hsync = 1'($urandom);
      px.px_valid = 1'($urandom);
      px.px_data  = DW'($urandom);
      cfg_clear   = 1'($urandom);
      cfg_pattern = 1'($urandom);
      @(posedge clk);
      #1;
      check("rst_out_a", 32'(out_a), 32'(IDLE));
      check("rst_out_b", 32'(out_b), 32'(IDLE));
      check("rst_stat_pixels", 32'(stat_pixels), 32'd0);
      check("rst_stat_lines", 32'(stat_lines), 32'd0);
      check("rst_stat_error", 32'(stat_error), 32'd0);
    end
    repeat (PIPE) sb.push_back('{a: IDLE, b: IDLE});

    // Single DDR pixel followed by a blanked cycle carrying all-ones data.
    step(1'b1, 1'b0, 1'b0, 1'b1, 24'h123456, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 24'hFFFFFF, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("ddr_out_a", 32'(out_a), 32'({3'b111, 12'h456}));
    check("ddr_out_b", 32'(out_b), 32'({3'b111, 12'h123}));
    blank(1'b0);
    @(posedge clk);
    #1;
    check("blank_out_a", 32'(out_a), 32'({3'b100, 12'h000}));
    check("blank_out_b", 32'(out_b), 32'({3'b100, 12'h000}));

    // Three frames of 4 x 640, closed by a vsync.
    vsync_pulse();
    repeat (3) begin
      repeat (4) line(640, 16, 1'b0, -1, 1'b0, 1'b0);
      vsync_pulse();
    end
    check("geom_pixels", 32'(stat_pixels), 32'd640);
    check("geom_lines", 32'(stat_lines), 32'd4);
    check("geom_error", 32'(stat_error), 32'd0);

    // Short line sets the sticky flag; cfg_clear drops it.
    line(640, 16, 1'b0, -1, 1'b0, 1'b0);
    line(639, 16, 1'b0, -1, 1'b0, 1'b0);
    check("short_error", 32'(stat_error), 32'd1);
    check("short_pixels", 32'(stat_pixels), 32'd639);
    vsync_pulse();
    check("short_lines", 32'(stat_lines), 32'd2);
    blank(1'b1);
    blank(1'b0);
    check("clear_error", 32'(stat_error), 32'd0);

    // px_en gaps mid-line: pads idle, monitor keeps counting.
    line(640, 16, 1'b0, 100, 1'b0, 1'b0);
    check("en_pixels_1", 32'(stat_pixels), 32'd640);
    line(640, 16, 1'b0, 300, 1'b0, 1'b0);
    check("en_pixels_2", 32'(stat_pixels), 32'd640);
    check("en_error", 32'(stat_error), 32'd0);

    // Mismatch and cfg_clear in the same cycle: the error is kept.
    line(600, 16, 1'b0, -1, 1'b1, 1'b0);
    check("clr_vs_err_error", 32'(stat_error), 32'd1);
    check("clr_vs_err_pixels", 32'(stat_pixels), 32'd600);
    blank(1'b1);
    blank(1'b0);
    check("clear2_error", 32'(stat_error), 32'd0);

    // Line end coinciding with the vsync rise is counted in the old frame.
    vsync_pulse();
    check("frame3_lines", 32'(stat_lines), 32'd3);
    line(100, 16, 1'b0, -1, 1'b0, 1'b0);
    line(100, 16, 1'b0, -1, 1'b0, 1'b1);
    check("coincident_lines", 32'(stat_lines), 32'd2);
    check("coincident_error", 32'(stat_error), 32'd0);

`ifdef DLSC_DVI_TX_PATTERN_EN
    // Colour bars over one 256-pixel line.
    vsync_pulse();
    line(256, 16, 1'b1, -1, 1'b0, 1'b0);
    check("pattern_pixels", 32'(stat_pixels), 32'd256);
`endif

    repeat (PIPE) blank(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/dlsc_dvi_tx_formatter.md
# dlsc_dvi_tx_formatter

Parametrised pixel-to-pad formatter for DVI/parallel-RGB transmitter chips, for example the CH7301C. It sits between the pixel timing generator and the board-level DDR output-register/delay/pad wrapper. Each cycle it splits a generic multi-channel pixel into rising-edge and falling-edge pad words (or one SDR word), applies sync polarity, enforces blanking, and pipelines the result. It also measures frame geometry and flags lines of inconsistent length.

## Interface
Parameters:
- CHANNELS, 3: colour channels per pixel; channel 0 is in the LSBs of px_data.
- BITS, 8: bits per channel.
- DDR, 1: 1 = two edges per pixel, with OUT_BITS = CHANNELS*BITS/2. 0 = SDR, with OUT_BITS = CHANNELS*BITS.
- PIPE, 2: output pipeline depth, 1..4.
- HSYNC_POL, 0: 0 = hsync pin is active-low; 1 = active-high.
- VSYNC_POL, 0: same convention, for vsync.
- CNT_BITS, 12: width of the geometry counters.
- BAR_SHIFT, 5: test-bar width is 2^BAR_SHIFT pixels.

Ports:
- clk  in  1  pixel clock (the only clock).
- rst  in  1  synchronous, active-high reset.
- px_en  in  1  output enable; 0 forces the idle word.
- px_vsync, px_hsync  in  1  active-high syncs from the timing generator.
- px_valid  in  1  active video (DE).
- px_data  in  CHANNELS*BITS  pixel data.
- cfg_clear  in  1  clears stat_error.
- cfg_pattern  in  1  selects colour bars (present only with the macro).
- out_a  out  OUT_BITS+3  rising-edge word: {vsync_pin, hsync_pin, de, data}.
- out_b  out  OUT_BITS+3  falling-edge word, same layout. Equals out_a when DDR=0.
- stat_pixels  out  CNT_BITS  pixel count of the last complete line.
- stat_lines  out  CNT_BITS  line count of the last complete frame.
- stat_error  out  1  sticky line-length mismatch flag.

## Operation
- Data split, DDR=1: out_a.data = px_data[OUT_BITS-1:0]; out_b.data = px_data[2*OUT_BITS-1:OUT_BITS].
- Data split, DDR=0: both words carry the full px_data.
- Control bits:
  - de = px_valid.
  - sync_pin = HSYNC_POL ? px_hsync : !px_hsync. Vsync uses VSYNC_POL in the same way.
  - All control bits are identical in out_a and out_b.
- Blanking: when px_valid=0, the data field is forced to 0. Syncs pass through unchanged.
- Idle word: data=0, de=0, syncs at their inactive pin level. It is used when px_en=0 and is the reset value of every pipeline stage.
- Geometry monitor:
  - pix_cnt increments on each valid cycle and saturates at 2^CNT_BITS-1.
  - Falling edge of px_valid (line end):
    - If line_cnt>0 and pix_cnt != stat_pixels, stat_error is set.
    - stat_pixels <= pix_cnt; pix_cnt <= 0; line_cnt increments, saturating.
  - Rising edge of px_vsync: stat_lines <= line_cnt; line_cnt <= 0.
  - Edge detection uses one-cycle registered copies of px_valid and px_vsync.
- Simultaneous events:
  - Line end and vsync rise in the same cycle: the line is counted first, so stat_lines includes it.
  - cfg_clear and an error in the same cycle: the error wins, and stat_error stays 1.
- px_en=0: the monitor keeps running. Only the pad words are forced to idle.
- rst mid-line: counters and stat_* return to 0. The first line after reset never flags an error.

## Timing
- Latency: inputs to out_a/out_b is exactly PIPE cycles. stat_* update 1 cycle after the triggering edge is sampled.
- No back-pressure; every input is consumed every cycle.
- Reset values:
  - out_a and out_b: idle word.
  - stat_pixels, stat_lines, stat_error: 0.
  - Internal counters and edge registers: 0.
- px_en is sampled at pipeline entry, so its effect appears PIPE cycles later.

## Configuration
- DLSC_DVI_TX_PATTERN_EN defined:
  - cfg_pattern exists.
  - When cfg_pattern=1 and px_valid=1, the data field is replaced by colour bars.
  - Bar index: idx = (pix_cnt >> BAR_SHIFT) mod 8, where pix_cnt is the value before this pixel's increment.
  - Channel c is all-ones iff bit (c mod 3) of (7-idx) is 1; otherwise it is 0.
- DLSC_DVI_TX_PATTERN_EN undefined: cfg_pattern and the bar logic are absent, and data always comes from px_data.

## Structure
- Shared package dlsc_dvi_tx_pkg holds:
  - word layout indices (DE, HSYNC, VSYNC bit positions relative to OUT_BITS);
  - the idle-word builder function;
  - the 8-entry bar colour constant.
- Sub-module dlsc_dvi_tx_geom_mon contains the edge detectors, counters, stat registers and error flag. It is shared with future receivers.
- Top level keeps the split/blank/polarity mux and the PIPE-deep register chain.

## Test plan
- Reset: hold rst for 3 cycles with random inputs → out_a = out_b = {1,1,0,0x000} (POL=0); all stat_* = 0.
- DDR pixel, PIPE=2: px_data=0x123456, valid=1 → after exactly 2 cycles, out_a.data=0x456, out_b.data=0x123, de=1.
- Blanking and polarity: valid=0, hsync=1, data=0xFFFFFF, HSYNC_POL=0 → data=0, hsync_pin=0, de=0.
- Geometry: 3 frames of 4 lines × 640 pixels → stat_pixels=640, stat_lines=4, stat_error=0. Then make one line 639 pixels → stat_error=1; cfg_clear → 0.
- px_en toggle mid-line: px_en=0 for 5 cycles → idle words 2 cycles later; stat_pixels still 640 at line end.
- Pattern (macro on), BAR_SHIFT=5: pixels 0, 32 and 224 → 0xFFFFFF, 0xFFFF00, 0x000000.
